id_reg_file: RTL and testbench

Architectural register file for the 64-bit ARM pipeline, sitting in the ID stage as the receiving end of the writeback path. It holds X0–X30 plus a hardwired-zero X31. It accepts one write per cycle from the WB stage and serves two combinational read ports to decode. A write-through bypass lets an instruction in ID read a value that WB is committing in the same cycle.

---
 rtl/id_reg_file_pkg.sv | 18 +
 rtl/id_reg_file_reg64_en.sv | 34 +++
 rtl/id_reg_file.sv | 60 ++++++
 tb/tb_id_reg_file.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/id_reg_file_pkg.sv
// Shared definitions for the ID-stage register file and the WB stage.
//   ZERO_REG      : address of the hardwired-zero register X31
//   REG_W         : architectural register width
//   NUM_ARCH_REGS : registers that actually have storage (X0-X30)
//   wb_port_t     : writeback port bundle driven by WB, consumed by ID
package structures;

  localparam logic [4:0] ZERO_REG      = 5'd31;
  localparam int         REG_W         = 64;
  localparam int         NUM_ARCH_REGS = 31;

  typedef struct packed {
    logic             reg_write;
    logic [4:0]       write_reg;
    logic [REG_W-1:0] write_data;
  } wb_port_t;

endpackage

// File: rtl/id_reg_file_reg64_en.sv
// reg64_en: one architectural register with synchronous reset and load enable.
//   clk : clock
//   rst : synchronous active-high clear (wins over en)
//   en  : load enable
//   d   : load data
//   q   : stored value
module reg64_en
  import structures::*;
#(
  parameter int W = REG_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en) q_d = d;
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/id_reg_file.sv
// id_reg_file: architectural register file X0-X30 plus hardwired-zero X31.
// One write per cycle from WB, two combinational read ports with write-through
// bypass so ID sees the value WB commits in the same cycle.
//   clk, rst                                   : clock, synchronous active-high reset
//   id_reg_write, id_write_reg, id_write_data  : writeback port
//   id_read_reg1, id_read_reg2                 : read addresses
//   id_read_data1, id_read_data2               : read data
module id_reg_file
  import structures::*;
#(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_reg_write,
  input  logic [ADDR_W-1:0] id_write_reg,
  input  logic [DATA_W-1:0] id_write_data,
  input  logic [ADDR_W-1:0] id_read_reg1,
  input  logic [ADDR_W-1:0] id_read_reg2,
  output logic [DATA_W-1:0] id_read_data1,
  output logic [DATA_W-1:0] id_read_data2
);

  wb_port_t wb;
  assign wb = '{reg_write: id_reg_write, write_reg: id_write_reg, write_data: id_write_data};

  // Entry 31 has no storage; tying it to zero lets the read mux cover X31
  // without a separate address check.
  logic [DATA_W-1:0] rd_arr [NUM_REGS];
  assign rd_arr[NUM_REGS-1] = '0;

  // The decoder never matches address 31 because no register exists there,
  // which is what discards writes to X31. Reset gating makes reset win.
  for (genvar gi = 0; gi < NUM_ARCH_REGS; gi++) begin : g_regs
    logic we;
    assign we = wb.reg_write & ~rst & (wb.write_reg == ADDR_W'(gi));

    reg64_en #(.W(DATA_W)) u_reg (
      .clk (clk),
      .rst (rst),
      .en  (we),
      .d   (wb.write_data),
      .q   (rd_arr[gi])
    );
  end

  // Bypass is suppressed during reset and for X31.
  logic byp1;
  logic byp2;

  always_comb begin
    byp1 = ~rst & wb.reg_write & (wb.write_reg == id_read_reg1) & (id_read_reg1 != ZERO_REG);
    byp2 = ~rst & wb.reg_write & (wb.write_reg == id_read_reg2) & (id_read_reg2 != ZERO_REG);
    id_read_data1 = byp1 ? wb.write_data : rd_arr[id_read_reg1];
    id_read_data2 = byp2 ? wb.write_data : rd_arr[id_read_reg2];
  end

endmodule

// File: tb/tb_id_reg_file.sv
module tb_id_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_reg_write;
  logic [4:0]  id_write_reg;
  logic [63:0] id_write_data;
  logic [4:0]  id_read_reg1;
  logic [4:0]  id_read_reg2;
  logic [63:0] id_read_data1;
  logic [63:0] id_read_data2;

  int total = 0;
  int bad   = 0;

  logic [63:0] model [32];

  always #5 clk = ~clk;

  id_reg_file dut (
    .clk           (clk),
    .rst           (rst),
    .id_reg_write  (id_reg_write),
    .id_write_reg  (id_write_reg),
    .id_write_data (id_write_data),
    .id_read_reg1  (id_read_reg1),
    .id_read_reg2  (id_read_reg2),
    .id_read_data1 (id_read_data1),
    .id_read_data2 (id_read_data2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Set inputs, then let combinational outputs settle.
  task automatic drive(input logic r, input logic we, input logic [4:0] wa,
                       input logic [63:0] wd, input logic [4:0] r1, input logic [4:0] r2);
    rst = r; id_reg_write = we; id_write_reg = wa; id_write_data = wd;
    id_read_reg1 = r1; id_read_reg2 = r2;
    #1;
  endtask

  // Clock edge; the reference array follows the architectural rules.
  task automatic tick();
    logic        r, we;
    logic [4:0]  wa;
    logic [63:0] wd;
    r = rst; we = id_reg_write; wa = id_write_reg; wd = id_write_data;
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < 32; i++) model[i] = '0;
    end else if (we && wa != 5'd31) begin
      model[wa] = wd;
    end
  endtask

  function automatic logic [63:0] exp_rd(input logic [4:0] a);
    if (a == 5'd31) return '0;
    if (!rst && id_reg_write && id_write_reg == a) return id_write_data;
    return model[a];
  endfunction

  localparam logic [63:0] V3 = 64'h0123_4567_89AB_CDEF;

  initial begin
    for (int i = 0; i < 32; i++) model[i] = '0;

    // Reset from power-up
    drive(1'b1, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0);
    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 1'b0, 5'd0, 64'h0, 5'(a), 5'(31 - a));
      check("por_rd1", id_read_data1, 64'h0);
      check("por_rd2", id_read_data2, 64'h0);
    end

    // Write X5 then pulse reset: everything clears
    drive(1'b0, 1'b1, 5'd5, 64'hDEAD_BEEF, 5'd5, 5'd0);
    check("x5_bypass", id_read_data1, 64'hDEAD_BEEF);
    tick();
    drive(1'b1, 1'b0, 5'd0, 64'h0, 5'd5, 5'd5);
    check("x5_stored_in_rst", id_read_data1, 64'hDEAD_BEEF);
    tick();
    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 1'b0, 5'd0, 64'h0, 5'(a), 5'(a));
      check("rst_clear_rd1", id_read_data1, 64'h0);
      check("rst_clear_rd2", id_read_data2, 64'h0);
    end

    // Write X3, neighbours untouched
    drive(1'b0, 1'b1, 5'd3, V3, 5'd2, 5'd4);
    tick();
    drive(1'b0, 1'b0, 5'd0, 64'h0, 5'd3, 5'd2);
    check("x3_read", id_read_data1, V3);
    check("x2_zero", id_read_data2, 64'h0);
    drive(1'b0, 1'b0, 5'd0, 64'h0, 5'd4, 5'd3);
    check("x4_zero", id_read_data1, 64'h0);
    check("x3_port2", id_read_data2, V3);

    // Bypass on both ports before the edge
    drive(1'b0, 1'b1, 5'd7, 64'h55, 5'd7, 5'd7);
    check("byp7_rd1", id_read_data1, 64'h55);
    check("byp7_rd2", id_read_data2, 64'h55);
    tick();
    drive(1'b0, 1'b0, 5'd7, 64'hAA, 5'd7, 5'd3);
    check("x7_stored_no_we", id_read_data1, 64'h55);
    check("x3_still", id_read_data2, V3);

    // X31 writes are discarded and never bypassed
    drive(1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31);
    check("x31_same_rd1", id_read_data1, 64'h0);
    check("x31_same_rd2", id_read_data2, 64'h0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 64'h0, 5'd31, 5'd7);
    check("x31_later", id_read_data1, 64'h0);
    check("x7_after_x31", id_read_data2, 64'h55);
    drive(1'b0, 1'b0, 5'd0, 64'h0, 5'd0, 5'd30);
    check("x0_after_x31", id_read_data1, 64'h0);
    check("x30_after_x31", id_read_data2, 64'h0);

    // Reset beats a simultaneous write; bypass suppressed during reset
    drive(1'b1, 1'b1, 5'd9, 64'h99, 5'd9, 5'd3);
    check("rst_no_bypass", id_read_data1, 64'h0);
    check("rst_stored_x3", id_read_data2, V3);
    tick();
    drive(1'b0, 1'b0, 5'd0, 64'h0, 5'd9, 5'd3);
    check("x9_dropped", id_read_data1, 64'h0);
    check("x3_cleared", id_read_data2, 64'h0);

    // First write after reset lands normally
    drive(1'b0, 1'b1, 5'd9, 64'h77, 5'd1, 5'd1);
    tick();
    drive(1'b0, 1'b0, 5'd0, 64'h0, 5'd9, 5'd1);
    check("x9_post_rst", id_read_data1, 64'h77);
    check("x1_untouched", id_read_data2, 64'h0);

    // Back-to-back writes to one register
    drive(1'b0, 1'b1, 5'd10, 64'h1, 5'd10, 5'd9);
    check("b2b_byp1", id_read_data1, 64'h1);
    tick();
    drive(1'b0, 1'b1, 5'd10, 64'h2, 5'd10, 5'd10);
    check("b2b_byp2_rd1", id_read_data1, 64'h2);
    check("b2b_byp2_rd2", id_read_data2, 64'h2);
    tick();
    drive(1'b0, 1'b0, 5'd0, 64'h0, 5'd10, 5'd9);
    check("b2b_last_wins", id_read_data1, 64'h2);
    check("x9_kept", id_read_data2, 64'h77);

    // Random soak against the reference array
    for (int c = 0; c < 3000; c++) begin
      logic [4:0] wa, r1, r2;
      wa = 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), wa,
            {$urandom, $urandom}, r1, r2);
      check("soak_rd1", id_read_data1, exp_rd(r1));
      check("soak_rd2", id_read_data2, exp_rd(r2));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
